// File: rtl/board_pkg.sv
// board_pkg: constants and helpers shared by the board renderer.
//   TILE_W_DEF / TILE_H_DEF : default tile size in pixels, including the
//                             one-pixel grid column and grid row
//   BOARD_DIM / NUM_CELLS   : the board is 8x8 cells
//   ST_*                    : controller state encoding
//   COLOR_*                 : 3-bit RGB palette
//   cell_color()            : interior color of a cell from its latched state
package board_pkg;

  localparam int TILE_W_DEF = 20;
  localparam int TILE_H_DEF = 15;
  localparam int BOARD_DIM  = 8;
  localparam int NUM_CELLS  = BOARD_DIM * BOARD_DIM;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] COLOR_GRID   = 3'b000;
  localparam logic [2:0] COLOR_MINE   = 3'b100;
  localparam logic [2:0] COLOR_STEP   = 3'b111;
  localparam logic [2:0] COLOR_FLAG   = 3'b110;
  localparam logic [2:0] COLOR_HIDDEN = 3'b001;

  // A mine is shown once stepped on or when the whole board is revealed;
  // a visible mine outranks the step color, which outranks a flag.
  function automatic logic [2:0] cell_color(input logic mine, input logic flag,
                                            input logic step, input logic reveal);
    if (mine && (step || reveal)) return COLOR_MINE;
    else if (step)                return COLOR_STEP;
    else if (flag)                return COLOR_FLAG;
    else                          return COLOR_HIDDEN;
  endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// tile_pixel_counter: row-major pixel sweep across one tile.
//   clk    : system clock
//   reset  : synchronous, active-low reset
//   clear  : return to pixel (0,0)
//   enable : advance one pixel (px first, py on px wrap)
//   px, py : current pixel offset inside the tile
//   last   : current pixel is the bottom-right corner
module tile_pixel_counter #(
  parameter int TILE_W = 20,
  parameter int TILE_H = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic       last
);

  localparam logic [7:0] PX_MAX = 8'(TILE_W - 1);
  localparam logic [6:0] PY_MAX = 7'(TILE_H - 1);

  logic [7:0] px_reg;
  logic [6:0] py_reg;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      px_reg <= '0;
      py_reg <= '0;
    end else if (enable) begin
      if (px_reg == PX_MAX) begin
        px_reg <= '0;
        py_reg <= (py_reg == PY_MAX) ? '0 : py_reg + 7'd1;
      end else begin
        px_reg <= px_reg + 8'd1;
      end
    end
  end

  assign px   = px_reg;
  assign py   = py_reg;
  assign last = (px_reg == PX_MAX) && (py_reg == PY_MAX);

endmodule

// File: rtl/board_render_ctrl.sv
// board_render_ctrl: redraws the 8x8 minesweeper board (or one cell of it)
// into a 160x120 frame buffer, one pixel per clock.
//   clk, reset           : system clock, synchronous active-low reset
//   start_all            : redraw all 64 cells (wins over start_cell)
//   start_cell, cell_sel : redraw one cell, cell_sel = {row[2:0], col[2:0]}
//   mine_map, flag_map,
//   step_map             : per-cell state, latched at start
//   reveal_all           : show every mine (game over), latched at start
//   x_out, y_out,
//   color_out, plot      : pixel write; values hold while plot is low
//   busy                 : controller is not idle
//   done                 : one-cycle pulse when the redraw completes
module board_render_ctrl
  import board_pkg::*;
#(
  parameter int TILE_W = TILE_W_DEF,
  parameter int TILE_H = TILE_H_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_all,
  input  logic        start_cell,
  input  logic [5:0]  cell_sel,
  input  logic [63:0] mine_map,
  input  logic [63:0] flag_map,
  input  logic [63:0] step_map,
  input  logic        reveal_all,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  color_out,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] PX_MAX    = 8'(TILE_W - 1);
  localparam logic [6:0] PY_MAX    = 7'(TILE_H - 1);
  localparam logic [5:0] LAST_CELL = 6'(NUM_CELLS - 1);

  logic [1:0]  state_reg;
  logic [5:0]  cell_reg;
  logic        mode_all_reg;
  logic [63:0] mine_reg, flag_reg, step_reg;
  logic        reveal_reg;
  logic [7:0]  x0_reg;
  logic [6:0]  y0_reg;
  logic [2:0]  color_reg;
  logic [7:0]  x_hold_reg;
  logic [6:0]  y_hold_reg;
  logic [2:0]  color_hold_reg;

  logic [7:0]  px;
  logic [6:0]  py;
  logic        last_pixel;
  logic [7:0]  x_draw;
  logic [6:0]  y_draw;
  logic [2:0]  color_draw;

  tile_pixel_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg == ST_SETUP),
    .enable (state_reg == ST_DRAW),
    .px     (px),
    .py     (py),
    .last   (last_pixel)
  );

  assign x_draw     = x0_reg + px;
  assign y_draw     = y0_reg + py;
  assign color_draw = ((px == PX_MAX) || (py == PY_MAX)) ? COLOR_GRID : color_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cell_reg       <= '0;
      mode_all_reg   <= 1'b0;
      mine_reg       <= '0;
      flag_reg       <= '0;
      step_reg       <= '0;
      reveal_reg     <= 1'b0;
      x0_reg         <= '0;
      y0_reg         <= '0;
      color_reg      <= '0;
      x_hold_reg     <= '0;
      y_hold_reg     <= '0;
      color_hold_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_all || start_cell) begin
            mine_reg     <= mine_map;
            flag_reg     <= flag_map;
            step_reg     <= step_map;
            reveal_reg   <= reveal_all;
            mode_all_reg <= start_all;
            cell_reg     <= start_all ? 6'd0 : cell_sel;
            state_reg    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Origins wrap in 8/7-bit arithmetic, matching the frame buffer width.
          x0_reg    <= 8'(32'(cell_reg[2:0]) * TILE_W);
          y0_reg    <= 7'(32'(cell_reg[5:3]) * TILE_H);
          color_reg <= cell_color(mine_reg[cell_reg], flag_reg[cell_reg],
                                  step_reg[cell_reg], reveal_reg);
          state_reg <= ST_DRAW;
        end
        ST_DRAW: begin
          // Remember the pixel being written so the outputs can hold it
          // once plot drops.
          x_hold_reg     <= x_draw;
          y_hold_reg     <= y_draw;
          color_hold_reg <= color_draw;
          if (last_pixel) begin
            if (!mode_all_reg || cell_reg == LAST_CELL) begin
              state_reg <= ST_DONE;
            end else begin
              cell_reg  <= cell_reg + 6'd1;
              state_reg <= ST_SETUP;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign plot      = (state_reg == ST_DRAW);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign x_out     = plot ? x_draw     : x_hold_reg;
  assign y_out     = plot ? y_draw     : y_hold_reg;
  assign color_out = plot ? color_draw : color_hold_reg;

endmodule

// File: tb/tb_board_render_ctrl.sv
// tb_board_render_ctrl: directed self-checking bench for board_render_ctrl.
// Each redraw is captured into a shadow frame buffer and then compared
// against hand-computed pixel values, counts and cycle positions.
module tb_board_render_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_all = 1'b0;
  logic        start_cell = 1'b0;
  logic [5:0]  cell_sel = '0;
  logic [63:0] mine_map = '0;
  logic [63:0] flag_map = '0;
  logic [63:0] step_map = '0;
  logic        reveal_all = 1'b0;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  color_out;
  logic        plot, busy, done;

  int checks = 0;
  int failures = 0;

  // per-run capture
  logic [2:0] fb [0:159][0:119];
  int plots, done_cnt, done_k, first_k, end_k, n_flag_color, oob;
  int xmin, xmax, ymin, ymax;

  board_render_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_all  (start_all),
    .start_cell (start_cell),
    .cell_sel   (cell_sel),
    .mine_map   (mine_map),
    .flag_map   (flag_map),
    .step_map   (step_map),
    .reveal_all (reveal_all),
    .x_out      (x_out),
    .y_out      (y_out),
    .color_out  (color_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Launch a redraw on the next falling edge; the DUT samples it on the
  // following rising edge (cycle k=1 of run_draw is then SETUP).
  task automatic launch(input logic a, input logic c, input logic [5:0] sel);
    @(negedge clk);
    start_all  = a;
    start_cell = c;
    cell_sel   = sel;
  endtask

  // action 1: pulse start_cell mid-draw and flip flag_map to all ones.
  task automatic run_draw(input string name, input int budget, input int action);
    int k;
    bit fin;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        fb[x][y] = 3'b010;
    plots = 0; done_cnt = 0; done_k = -1; first_k = -1; end_k = -1;
    n_flag_color = 0; oob = 0;
    xmin = 999; xmax = -1; ymin = 999; ymax = -1;
    k = 0;
    fin = 0;
    while (!fin && k < budget) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start_all  = 1'b0;
        start_cell = 1'b0;
      end
      if (plot) begin
        plots++;
        if (first_k < 0) first_k = k;
        if (color_out == 3'b110) n_flag_color++;
        if (x_out < 160 && y_out < 120) fb[x_out][y_out] = color_out;
        else oob++;
        if (int'(x_out) < xmin) xmin = int'(x_out);
        if (int'(x_out) > xmax) xmax = int'(x_out);
        if (int'(y_out) < ymin) ymin = int'(y_out);
        if (int'(y_out) > ymax) ymax = int'(y_out);
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (action == 1 && k == 500)  flag_map = '1;
      if (action == 1 && k == 1000) begin start_cell = 1'b1; cell_sel = 6'd5; end
      if (action == 1 && k == 1001) start_cell = 1'b0;
      if (k > 1 && !busy) begin
        fin = 1;
        end_k = k;
      end
    end
    check({name, "_finished"}, int'(fin), 1);
    $display("run %s: plots=%0d first=%0d done_k=%0d end_k=%0d", name, plots, first_k, done_k, end_k);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_plot",  int'(plot), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_x",     int'(x_out), 0);
    check("rst_y",     int'(y_out), 0);
    check("rst_color", int'(color_out), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // ---------------- full redraw, empty maps ----------------
    launch(1'b1, 1'b0, 6'd0);
    run_draw("all_empty", 20000, 0);
    check("all_plots",     plots, 19200);
    check("all_first",     first_k, 2);
    check("all_done_cnt",  done_cnt, 1);
    check("all_done_k",    done_k, 19265);
    check("all_busy_drop", end_k, 19266);
    check("all_oob",       oob, 0);
    check("c0_interior",   int'(fb[1][1]), 1);
    check("c0_interior2",  int'(fb[18][13]), 1);
    check("c0_grid_col",   int'(fb[19][0]), 0);
    check("c0_grid_row",   int'(fb[0][14]), 0);
    check("c63_corner",    int'(fb[159][119]), 0);
    check("c54_interior",  int'(fb[125][95]), 1);

    // ---------------- single cell 63, stepped ----------------
    step_map = 64'd1 << 63;
    launch(1'b0, 1'b1, 6'd63);
    run_draw("cell63_step", 400, 0);
    check("c63_plots", plots, 300);
    check("c63_xmin",  xmin, 140);
    check("c63_xmax",  xmax, 159);
    check("c63_ymin",  ymin, 105);
    check("c63_ymax",  ymax, 119);
    check("c63_first", int'(fb[140][105]), 7);
    check("c63_last",  int'(fb[159][119]), 0);
    check("c63_done_k", done_k, 302);
    check("c63_busy_drop", end_k, 303);
    // outputs hold the last plotted pixel while idle
    check("hold_x",     int'(x_out), 159);
    check("hold_y",     int'(y_out), 119);
    check("hold_color", int'(color_out), 0);
    step_map = '0;

    // ---------------- cell 9 mine, revealed vs hidden ----------------
    mine_map   = 64'd1 << 9;
    reveal_all = 1'b1;
    launch(1'b0, 1'b1, 6'd9);
    run_draw("cell9_reveal", 400, 0);
    check("c9r_plots", plots, 300);
    check("c9r_tl",    int'(fb[20][15]), 4);
    check("c9r_br",    int'(fb[38][28]), 4);
    check("c9r_grid",  int'(fb[39][29]), 0);
    reveal_all = 1'b0;
    launch(1'b0, 1'b1, 6'd9);
    run_draw("cell9_hidden", 400, 0);
    check("c9h_tl", int'(fb[20][15]), 1);
    check("c9h_br", int'(fb[38][28]), 1);
    // a flag on an unrevealed mine shows as a flag
    flag_map = 64'd1 << 9;
    launch(1'b0, 1'b1, 6'd9);
    run_draw("cell9_flag", 400, 0);
    check("c9f_mid", int'(fb[30][20]), 6);
    mine_map = '0;
    flag_map = '0;

    // ------- both starts together, late start_cell and flag change -------
    launch(1'b1, 1'b1, 6'd5);
    run_draw("both_starts", 20000, 1);
    check("both_plots",    plots, 19200);
    check("both_done_k",   done_k, 19265);
    check("both_done_cnt", done_cnt, 1);
    check("both_no_flag",  n_flag_color, 0);
    check("both_c0",       int'(fb[1][1]), 1);
    flag_map = '0;

    // ---------------- reset in the middle of a full redraw ----------------
    begin
      int k;
      int np;
      launch(1'b1, 1'b0, 6'd0);
      np = 0;
      k = 0;
      while (np < 5000 && k < 6000) begin
        @(negedge clk);
        k++;
        if (k == 1) start_all = 1'b0;
        if (plot) np++;
      end
      check("mid_reach_5000", np, 5000);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_plot", int'(plot), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_x",    int'(x_out), 0);
      check("mid_rst_color", int'(color_out), 0);
      reset = 1'b1;
      np = 0;
      repeat (400) begin
        @(negedge clk);
        if (plot) np++;
      end
      check("mid_no_plots", np, 0);
      $display("run mid_reset: plots_after_reset=%0d", np);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
